// File: rtl/block_serial_subtractor.sv
// block_serial_subtractor: 16-bit a - b - bin computed one 4-bit carry-skip block per cycle,
// with a valid/ready handshake on both sides and a count of skipped blocks.
module block_serial_subtractor (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        bin,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] diff,
    output logic        bout,
    output logic [2:0]  skip_cnt
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    state_t      state_q, state_d;
    logic [15:0] a_q, a_d, b_q, b_d, acc_q, acc_d, diff_q, diff_d;
    logic [1:0]  idx_q, idx_d;
    logic [2:0]  skip_q, skip_d, skcnt_q, skcnt_d;
    logic        carry_q, carry_d, bout_q, bout_d;
    logic [3:0]  nb;
    logic [4:0]  sum;
    logic        p, cout;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && in_valid)      state_d = CALC;
        else if (state_q == CALC && idx_q == 2'd3) state_d = DONE;
        else if (state_q == DONE && out_ready) state_d = IDLE;
    end
    always_comb begin
        in_ready  = state_q == IDLE;
        out_valid = state_q == DONE;
        diff      = diff_q;
        bout      = bout_q;
        skip_cnt  = skcnt_q;
    end
    // Operands shift right so the active block is always the low nibble.
    assign nb   = ~b_q[3:0];
    assign p    = &(a_q[3:0] ^ nb);
    assign sum  = {1'b0, a_q[3:0]} + {1'b0, nb} + {4'b0, carry_q};
    assign cout = p ? carry_q : sum[4];
    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        carry_d = carry_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        skcnt_d = skcnt_q;
        if (state_q == IDLE && in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = ~bin;
            acc_d   = '0;
            idx_d   = '0;
            skip_d  = '0;
        end else if (state_q == CALC) begin
            a_d     = a_q >> 4;
            b_d     = b_q >> 4;
            acc_d   = {sum[3:0], acc_q[15:4]};
            idx_d   = idx_q + 2'd1;
            skip_d  = skip_q + {2'b0, p};
            carry_d = cout;
            if (idx_q == 2'd3) begin
                diff_d  = acc_d;
                bout_d  = ~cout;
                skcnt_d = skip_d;
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            idx_q   <= '0;
            skip_q  <= '0;
            carry_q <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            skcnt_q <= '0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            skip_q  <= skip_d;
            carry_q <= carry_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            skcnt_q <= skcnt_d;
        end
    end
endmodule

// File: tb/tb_block_serial_subtractor.sv
// tb_block_serial_subtractor: directed and random operand sets checked by a queue-based scoreboard.
module tb_block_serial_subtractor;
    logic        clk = 0, rst_n = 0, in_valid = 0, bin = 0;
    logic        dir_ready = 1, rnd_ready = 1, rnd_mode = 0;
    logic [15:0] a = 0, b = 0;
    logic        in_ready, out_valid, out_ready, bout;
    logic [15:0] diff;
    logic [2:0]  skip_cnt;
    typedef struct packed { logic [15:0] d; logic bo; logic [2:0] s; } res_t;
    res_t exp_q[$];
    int checks = 0, errors = 0;
    block_serial_subtractor dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .bin(bin), .out_valid(out_valid), .out_ready(out_ready),
        .diff(diff), .bout(bout), .skip_cnt(skip_cnt)
    );
    assign out_ready = rnd_mode ? rnd_ready : dir_ready;
    always #5 clk = ~clk;
    initial forever begin
        @(posedge clk);
        #1 rnd_ready = ($urandom_range(0, 3) != 0);
    end
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_result: got diff %h with no accepted input", diff);
            end else begin
                res_t e;
                e = exp_q.pop_front();
                chk("diff", {16'h0, diff}, {16'h0, e.d});
                chk("bout", {31'h0, bout}, {31'h0, e.bo});
                chk("skip_cnt", {29'h0, skip_cnt}, {29'h0, e.s});
            end
        end
    end
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic c);
        res_t r;
        logic [16:0] t;
        t = {1'b0, x} - {1'b0, y} - {16'h0, c};
        r.d = t[15:0];
        r.bo = t[16];
        r.s = 0;
        for (int k = 0; k < 4; k++) if (x[4*k +: 4] == y[4*k +: 4]) r.s = r.s + 3'd1;
        return r;
    endfunction
    task automatic send(input logic [15:0] x, input logic [15:0] y, input logic c,
                        input bit push, input res_t e);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            if (rnd_mode) begin in_valid = 1'($urandom); a = 16'($urandom); b = 16'($urandom); end
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
            in_valid = 0;
            return;
        end
        a = x; b = y; bin = c; in_valid = 1;
        if (push) exp_q.push_back(e);
        @(posedge clk);
        #1 in_valid = 0;
        a = 16'($urandom); b = 16'($urandom); bin = 1'($urandom);
    endtask
    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin @(negedge clk); n++; end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending results expected 0", exp_q.size());
        end
    endtask
    typedef struct packed { logic [15:0] x; logic [15:0] y; logic c; res_t r; } vec_t;
    vec_t vecs[8] = '{
        '{16'h0064, 16'h0032, 1'b0, '{16'h0032, 1'b0, 3'd2}},
        '{16'h0000, 16'h0001, 1'b0, '{16'hFFFF, 1'b1, 3'd3}},
        '{16'h1234, 16'h1234, 1'b1, '{16'hFFFF, 1'b1, 3'd4}},
        '{16'h1234, 16'h1234, 1'b0, '{16'h0000, 1'b0, 3'd4}},
        '{16'h0000, 16'h0000, 1'b1, '{16'hFFFF, 1'b1, 3'd4}},
        '{16'hFFFF, 16'h0001, 1'b1, '{16'hFFFD, 1'b0, 3'd0}},
        '{16'h1000, 16'h2000, 1'b0, '{16'hF000, 1'b1, 3'd3}},
        '{16'hABCD, 16'h1234, 1'b0, '{16'h9999, 1'b0, 3'd0}}
    };
    initial begin
        #1;
        chk("reset_in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset_out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_diff", {16'h0, diff}, 32'h0);
        @(negedge clk);
        rst_n = 1;
        send(vecs[0].x, vecs[0].y, vecs[0].c, 1, vecs[0].r);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1 chk("latency_not_yet", {31'h0, out_valid}, 32'h0);
        end
        @(posedge clk);
        #1 chk("latency_valid", {31'h0, out_valid}, 32'h1);
        for (int i = 1; i < 8; i++) send(vecs[i].x, vecs[i].y, vecs[i].c, 1, vecs[i].r);
        drain();
        dir_ready = 0;
        send(16'hFFFF, 16'h0000, 1'b0, 1, '{16'hFFFF, 1'b0, 3'd0});
        begin
            int n = 0;
            while (!out_valid && n < 20) begin @(negedge clk); n++; end
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_diff", {16'h0, diff}, 32'hFFFF);
            chk("stall_bout", {31'h0, bout}, 32'h0);
            chk("stall_out_valid", {31'h0, out_valid}, 32'h1);
            chk("stall_in_ready", {31'h0, in_ready}, 32'h0);
        end
        dir_ready = 1;
        drain();
        send(16'h8000, 16'h0001, 1'b0, 0, '0);
        @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("abort_diff", {16'h0, diff}, 32'h0);
        chk("abort_bout", {31'h0, bout}, 32'h0);
        chk("abort_skip", {29'h0, skip_cnt}, 32'h0);
        chk("abort_out_valid", {31'h0, out_valid}, 32'h0);
        chk("abort_in_ready", {31'h0, in_ready}, 32'h1);
        @(negedge clk);
        rst_n = 1;
        send(16'h8000, 16'h0001, 1'b0, 1, '{16'h7FFF, 1'b0, 3'd2});
        drain();
        rnd_mode = 1;
        for (int i = 0; i < 1000; i++) begin
            logic [15:0] x, y;
            logic c;
            x = 16'($urandom); y = 16'($urandom); c = 1'($urandom);
            if (i % 4 == 0) y = x;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send(x, y, c, 1, model(x, y, c));
        end
        drain();
        rnd_mode = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/block_serial_subtractor.md
BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 The block SHALL have no parameters; datapath width is fixed at 16 bits, processed as four 4-bit carry-skip blocks.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand set a/b/bin is valid.
REQ-005 in_ready  output  1  block can accept an operand set.
REQ-006 a  input  16  minuend.
REQ-007 b  input  16  subtrahend.
REQ-008 bin  input  1  borrow-in.
REQ-009 out_valid  output  1  result fields are valid.
REQ-010 out_ready  input  1  consumer accepts the result.
REQ-011 diff  output  16  (a - b - bin) mod 2^16.
REQ-012 bout  output  1  borrow-out; 1 iff a < b + bin (unsigned).
REQ-013 skip_cnt  output  3  number of blocks (0..4) whose carry was taken via the skip path.

Function
REQ-014 Arithmetic SHALL be a + ~b + ~bin on an internal carry chain; carry-in to block 0 = ~bin; bout = ~(carry-out of block 3).
REQ-015 Per block k, P_k = AND of the four bits of (a ^ ~b) for that block; when P_k=1 the block carry-out SHALL equal its carry-in (skip) and skip_cnt SHALL increment.
REQ-016 FSM states SHALL be IDLE, CALC, DONE.
REQ-017 IDLE: in_ready=1; on in_valid&in_ready, capture a, b, bin, clear block index and skip count, go to CALC.
REQ-018 CALC: one block per cycle, LSB block first; block result and carry registered each edge; after block 3 go to DONE.
REQ-019 Latency: handshake on edge T -> out_valid=1 after edge T+4, diff/bout/skip_cnt final and valid at that point.
REQ-020 in_ready SHALL be 0 in CALC and DONE; no operand overlap; in_valid outside IDLE is ignored.
REQ-021 DONE: out_valid=1; diff, bout, skip_cnt held stable while out_ready=0 (any number of cycles).
REQ-022 DONE with out_ready=1 on an edge: result consumed, out_valid drops, return to IDLE; in_ready=1 the following cycle (no same-cycle accept of new operands).
REQ-023 Operand inputs SHALL NOT be sampled after capture; changes on a/b/bin during CALC/DONE have no effect.
REQ-024 diff, bout, skip_cnt SHALL be visible only as final values in DONE; in IDLE/CALC they hold last completed result (0 after reset).
REQ-025 Wrap-around: a < b+bin produces two's-complement diff mod 2^16 with bout=1; a=b, bin=0 gives diff=0, bout=0.

Reset
REQ-026 rst_n=0 SHALL immediately force FSM=IDLE, in_ready=1, out_valid=0, diff=0, bout=0, skip_cnt=0, internal index/carry/operands cleared, independent of clk.
REQ-027 Reset asserted mid-CALC or in DONE SHALL abort the operation with no result delivered; after rst_n rises, the first handshake SHALL complete correctly.

Verification
REQ-028 a=0x0064, b=0x0032, bin=0 -> diff=0x0032, bout=0, skip_cnt=2, out_valid 4 cycles after accept.
REQ-029 a=0x0000, b=0x0001, bin=0 -> diff=0xFFFF, bout=1, skip_cnt=3.
REQ-030 a=b=0x1234, bin=1 -> diff=0xFFFF, bout=1, skip_cnt=4.
REQ-031 a=0xFFFF, b=0x0000, bin=0 with out_ready held 0 for 3 cycles in DONE -> diff=0xFFFF, bout=0 stable, out_valid=1, in_ready=0 throughout; released on out_ready=1.
REQ-032 Accept a=0x8000, b=0x0001, assert rst_n=0 in 2nd CALC cycle -> all outputs 0, in_ready=1; then a=0x8000, b=0x0001, bin=0 -> diff=0x7FFF, bout=0.
REQ-033 Random 1000 operand sets with random out_ready stalls and in_valid toggling -> every result matches a-b-bin reference, exactly one result per accepted input, no result without accept.
